// File: rtl/pipe_sequencer_pkg.sv
// Shared widths, slot count and FSM state type for the pipe sequencer.
package pipe_sequencer_pkg;

  localparam int unsigned NUM_PIPES = 5;
  localparam int unsigned X_W       = 11;
  localparam int unsigned Y_W       = 10;
  localparam int unsigned IDX_W     = 3;

  localparam logic [IDX_W-1:0] ROM_LAST = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_HALT
  } state_t;

  // ROM rotation index: 0..ROM_LAST then wrap.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == ROM_LAST) ? '0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipe obstacle: x position and top-edge registers plus scroll/respawn math.
module pipe_slot
  import pipe_sequencer_pkg::*;
#(
  parameter logic [X_W-1:0] X_INIT = 11'd640,
  parameter logic [X_W-1:0] SPEED  = 11'd2,
  parameter logic [X_W-1:0] SPAN   = 11'd1000,
  parameter logic [X_W-1:0] PIPE_W = 11'd40,
  parameter logic [X_W-1:0] BIRD_X = 11'd100
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_x,
  input  logic           load_y,
  input  logic           tick,
  input  logic [Y_W-1:0] y_in,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] yt,
  output logic           respawn_req,
  output logic           pass_bird
);

  logic [X_W-1:0] x_next;
  logic [X_W:0]   edge_now;
  logic [X_W:0]   edge_next;

  // Next x for a tick: step left, or wrap round by one full span when off-screen.
  always_comb begin
    respawn_req = (x < SPEED);
    x_next      = respawn_req ? (x + (SPAN - SPEED)) : (x - SPEED);
    edge_now    = {1'b0, x} + {1'b0, PIPE_W};
    edge_next   = {1'b0, x_next} + {1'b0, PIPE_W};
    pass_bird   = !respawn_req && (edge_now >= {1'b0, BIRD_X})
                                && (edge_next < {1'b0, BIRD_X});
  end

  // Position register: reloaded on game start, advanced on applied ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= X_INIT;
    end else if (load_x) begin
      x <= X_INIT;
    end else if (tick) begin
      x <= x_next;
    end
  end

  // Top-edge register: written during LOAD and one cycle after a respawn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yt <= '0;
    end else if (load_y) begin
      yt <= y_in;
    end
  end

endmodule

// File: rtl/pipe_sequencer.sv
// Pipe sequencer: game FSM, ROM index, respawn height fetch and score.
module pipe_sequencer
  import pipe_sequencer_pkg::*;
#(
  parameter logic [X_W-1:0] X_START = 11'd640,
  parameter logic [X_W-1:0] SPACING = 11'd200,
  parameter logic [X_W-1:0] SPEED   = 11'd2,
  parameter logic [X_W-1:0] PIPE_W  = 11'd40,
  parameter logic [Y_W-1:0] GAP     = 10'd100,
  parameter logic [X_W-1:0] BIRD_X  = 11'd100
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       Start,
  input  logic                       FrameTick,
  input  logic                       Collide,
  output logic [IDX_W-1:0]           RomIdx,
  input  logic [Y_W-1:0]             RomY0T,
  output logic [NUM_PIPES*X_W-1:0]   PipeX,
  output logic [NUM_PIPES*Y_W-1:0]   PipeYT,
  output logic [NUM_PIPES*Y_W-1:0]   PipeYB,
  output logic [7:0]                 Score,
  output logic                       Running
);

  localparam logic [X_W-1:0] SPAN = X_W'(32'(NUM_PIPES) * 32'(SPACING));

  state_t           state, state_next;
  logic [IDX_W-1:0] load_cnt;
  logic [IDX_W-1:0] pend_slot;
  logic [IDX_W-1:0] resp_slot;
  logic             pending;
  logic             pend_latch;
  logic             start_load;
  logic             load_step;
  logic             tick_apply;
  logic             any_respawn;

  logic [NUM_PIPES-1:0] respawn_req;
  logic [NUM_PIPES-1:0] pass_bird;
  logic [NUM_PIPES-1:0] load_y;
  logic [X_W-1:0]       x_q  [NUM_PIPES];
  logic [Y_W-1:0]       yt_q [NUM_PIPES];

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_next = state;
    start_load = 1'b0;
    load_step  = 1'b0;
    tick_apply = 1'b0;
    unique case (state)
      ST_IDLE, ST_HALT: begin
        if (Start) begin
          state_next = ST_LOAD;
          start_load = 1'b1;
        end
      end
      ST_LOAD: begin
        load_step = 1'b1;
        if (load_cnt == ROM_LAST) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (Collide) begin
          state_next = ST_HALT;
        end else if (FrameTick) begin
          tick_apply = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Lowest-numbered slot asking for respawn (at most one can per tick).
  always_comb begin
    any_respawn = 1'b0;
    resp_slot   = '0;
    for (int unsigned k = 0; k < NUM_PIPES; k++) begin
      if (respawn_req[k] && !any_respawn) begin
        any_respawn = 1'b1;
        resp_slot   = IDX_W'(k);
      end
    end
  end

  // A pending height fetch completes in RUN even if the same cycle carries a
  // new tick; the fetch reads RomY0T before RomIdx advances.
  assign pend_latch = pending && (state == ST_RUN);

  // ROM index and load counter: LOAD walks 0..4, RUN advances once per respawn.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      RomIdx   <= '0;
      load_cnt <= '0;
    end else if (start_load) begin
      RomIdx   <= '0;
      load_cnt <= '0;
    end else if (load_step) begin
      if (load_cnt != ROM_LAST) begin
        load_cnt <= load_cnt + 3'd1;
        RomIdx   <= load_cnt + 3'd1;
      end
    end else if (tick_apply && any_respawn) begin
      RomIdx <= next_idx(RomIdx);
    end
  end

  // Pending-slot register: remembers which slot needs its height next cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pending   <= 1'b0;
      pend_slot <= '0;
    end else if (start_load) begin
      pending   <= 1'b0;
    end else if (tick_apply && any_respawn) begin
      pending   <= 1'b1;
      pend_slot <= resp_slot;
    end else if (pend_latch) begin
      pending   <= 1'b0;
    end
  end

  // Score: one per pipe whose trailing edge crosses the bird, saturating.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Score <= '0;
    end else if (start_load) begin
      Score <= '0;
    end else if (tick_apply && (|pass_bird) && (Score != 8'hFF)) begin
      Score <= Score + 8'd1;
    end
  end

  assign Running = (state == ST_RUN);

  for (genvar k = 0; k < NUM_PIPES; k++) begin : g_slot
    localparam logic [IDX_W-1:0] K_IDX  = IDX_W'(k);
    localparam logic [X_W-1:0]   X_INIT = X_W'(32'(X_START) + k * 32'(SPACING));

    assign load_y[k] = (load_step && (load_cnt == K_IDX)) ||
                       (pend_latch && (pend_slot == K_IDX));

    pipe_slot #(
      .X_INIT (X_INIT),
      .SPEED  (SPEED),
      .SPAN   (SPAN),
      .PIPE_W (PIPE_W),
      .BIRD_X (BIRD_X)
    ) u_slot (
      .clk         (Clk),
      .rst_n       (Reset_n),
      .load_x      (start_load),
      .load_y      (load_y[k]),
      .tick        (tick_apply),
      .y_in        (RomY0T),
      .x           (x_q[k]),
      .yt          (yt_q[k]),
      .respawn_req (respawn_req[k]),
      .pass_bird   (pass_bird[k])
    );

    assign PipeX[k*X_W +: X_W]  = x_q[k];
    assign PipeYT[k*Y_W +: Y_W] = yt_q[k];
    assign PipeYB[k*Y_W +: Y_W] = yt_q[k] + GAP;
  end

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer with a behavioural pipe-height ROM.
module tb_pipe_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        frame_tick;
  logic        collide;
  logic [2:0]  rom_idx;
  logic [9:0]  rom_y;
  logic [54:0] pipe_x;
  logic [49:0] pipe_yt;
  logic [49:0] pipe_yb;
  logic [7:0]  score;
  logic        running;
  logic        rom_alt;

  int total;
  int bad;

  pipe_sequencer dut (
    .Clk       (clk),
    .Reset_n   (rst_n),
    .Start     (start),
    .FrameTick (frame_tick),
    .Collide   (collide),
    .RomIdx    (rom_idx),
    .RomY0T    (rom_y),
    .PipeX     (pipe_x),
    .PipeYT    (pipe_yt),
    .PipeYB    (pipe_yb),
    .Score     (score),
    .Running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] rom_val(input logic [2:0] idx);
    case (idx)
      3'd0:    return 10'd210;
      3'd1:    return 10'd252;
      3'd2:    return 10'd180;
      3'd3:    return 10'd110;
      3'd4:    return 10'd314;
      default: return 10'd0;
    endcase
  endfunction

  // Combinational ROM; rom_alt shifts contents so a late/early height fetch shows.
  always_comb rom_y = rom_val(rom_idx) + (rom_alt ? 10'd1 : 10'd0);

  function automatic logic [10:0] px(input int k);
    return pipe_x[k*11 +: 11];
  endfunction

  function automatic logic [9:0] pyt(input int k);
    return pipe_yt[k*10 +: 10];
  endfunction

  function automatic logic [9:0] pyb(input int k);
    return pipe_yb[k*10 +: 10];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_pulse();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [9:0] exp_yt [5];
    rst_n = 1'b0; start = 1'b0; frame_tick = 1'b0; collide = 1'b0; rom_alt = 1'b0;
    step();
    step();
    total++; if (rom_idx !== 3'd0) begin bad++; $display("FAIL reset_romidx: got %0d want 0", rom_idx); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running: got %0d want 0", running); end
    total++; if (score !== 8'd0) begin bad++; $display("FAIL reset_score: got %0d want 0", score); end
    for (int k = 0; k < 5; k++) begin
      exp_yt[k] = 10'd0;
      total++;
      if (px(k) !== 11'(640 + 200 * k)) begin
        bad++; $display("FAIL reset_x%0d: got %0d want %0d", k, px(k), 640 + 200 * k);
      end
      total++;
      if (pyt(k) !== exp_yt[k]) begin bad++; $display("FAIL reset_yt%0d: got %0d want 0", k, pyt(k)); end
    end
    total++; if (pyb(0) !== 10'd100) begin bad++; $display("FAIL reset_yb0: got %0d want 100", pyb(0)); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_load();
    logic [9:0] exp_yt [5];
    exp_yt[0] = 10'd210; exp_yt[1] = 10'd252; exp_yt[2] = 10'd180;
    exp_yt[3] = 10'd110; exp_yt[4] = 10'd314;
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (running !== 1'b0) begin bad++; $display("FAIL load_running: got %0d want 0", running); end
    step();
    step();
    total++; if (rom_idx !== 3'd2) begin bad++; $display("FAIL load_c2_romidx: got %0d want 2", rom_idx); end
    step();
    step();
    step();
    total++; if (running !== 1'b1) begin bad++; $display("FAIL run_entered: got %0d want 1", running); end
    total++; if (rom_idx !== 3'd4) begin bad++; $display("FAIL run_romidx: got %0d want 4", rom_idx); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (pyt(k) !== exp_yt[k]) begin bad++; $display("FAIL load_yt%0d: got %0d want %0d", k, pyt(k), exp_yt[k]); end
    end
    total++; if (pyb(0) !== 10'd310) begin bad++; $display("FAIL load_yb0: got %0d want 310", pyb(0)); end
    total++; if (px(0) !== 11'd640) begin bad++; $display("FAIL load_x0: got %0d want 640", px(0)); end
  endtask

  task automatic test_scroll_score();
    tick_pulse();
    total++; if (px(0) !== 11'd638) begin bad++; $display("FAIL scroll_x0: got %0d want 638", px(0)); end
    total++; if (px(4) !== 11'd1438) begin bad++; $display("FAIL scroll_x4: got %0d want 1438", px(4)); end
    repeat (289) tick_pulse();
    total++; if (px(0) !== 11'd60) begin bad++; $display("FAIL pre_pass_x0: got %0d want 60", px(0)); end
    total++; if (score !== 8'd0) begin bad++; $display("FAIL pre_pass_score: got %0d want 0", score); end
    tick_pulse();
    total++; if (px(0) !== 11'd58) begin bad++; $display("FAIL pass_x0: got %0d want 58", px(0)); end
    total++; if (score !== 8'd1) begin bad++; $display("FAIL pass_score: got %0d want 1", score); end
    total++; if (px(1) !== 11'd258) begin bad++; $display("FAIL pass_x1: got %0d want 258", px(1)); end
    repeat (29) tick_pulse();
    total++; if (px(0) !== 11'd0) begin bad++; $display("FAIL edge_x0: got %0d want 0", px(0)); end
    total++; if (rom_idx !== 3'd4) begin bad++; $display("FAIL edge_romidx: got %0d want 4", rom_idx); end
  endtask

  task automatic test_respawn();
    rom_alt = 1'b1;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    total++; if (px(0) !== 11'd998) begin bad++; $display("FAIL respawn_x0: got %0d want 998", px(0)); end
    total++; if (rom_idx !== 3'd0) begin bad++; $display("FAIL respawn_romidx: got %0d want 0", rom_idx); end
    total++; if (pyt(0) !== 10'd210) begin bad++; $display("FAIL respawn_yt0_early: got %0d want 210", pyt(0)); end
    total++; if (px(1) !== 11'd198) begin bad++; $display("FAIL respawn_x1: got %0d want 198", px(1)); end
    step();
    total++; if (pyt(0) !== 10'd211) begin bad++; $display("FAIL respawn_yt0: got %0d want 211", pyt(0)); end
    total++; if (pyb(0) !== 10'd311) begin bad++; $display("FAIL respawn_yb0: got %0d want 311", pyb(0)); end
    rom_alt = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Ticks on every cycle from tick 322 through 25690.
    frame_tick = 1'b1;
    repeat (25369) step();
    total++; if (score !== 8'd254) begin bad++; $display("FAIL sat_254: got %0d want 254", score); end
    step();
    total++; if (score !== 8'd255) begin bad++; $display("FAIL sat_255: got %0d want 255", score); end
    repeat (100) step();
    frame_tick = 1'b0;
    total++; if (score !== 8'd255) begin bad++; $display("FAIL sat_hold: got %0d want 255", score); end
    total++; if (px(0) !== 11'd58) begin bad++; $display("FAIL sat_x0: got %0d want 58", px(0)); end
    total++; if (px(1) !== 11'd258) begin bad++; $display("FAIL sat_x1: got %0d want 258", px(1)); end
  endtask

  task automatic test_collide();
    frame_tick = 1'b1;
    collide = 1'b1;
    step();
    frame_tick = 1'b0;
    collide = 1'b0;
    total++; if (running !== 1'b0) begin bad++; $display("FAIL halt_running: got %0d want 0", running); end
    total++; if (px(0) !== 11'd58) begin bad++; $display("FAIL halt_x0: got %0d want 58", px(0)); end
    total++; if (score !== 8'd255) begin bad++; $display("FAIL halt_score: got %0d want 255", score); end
    tick_pulse();
    total++; if (px(0) !== 11'd58) begin bad++; $display("FAIL halt_frozen_x0: got %0d want 58", px(0)); end
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (score !== 8'd0) begin bad++; $display("FAIL restart_score: got %0d want 0", score); end
    total++; if (px(0) !== 11'd640) begin bad++; $display("FAIL restart_x0: got %0d want 640", px(0)); end
    total++; if (rom_idx !== 3'd0) begin bad++; $display("FAIL restart_romidx: got %0d want 0", rom_idx); end
    repeat (5) step();
    total++; if (running !== 1'b1) begin bad++; $display("FAIL restart_running: got %0d want 1", running); end
    total++; if (pyt(4) !== 10'd314) begin bad++; $display("FAIL restart_yt4: got %0d want 314", pyt(4)); end
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (running !== 1'b1) begin bad++; $display("FAIL run_start_ignored: got %0d want 1", running); end
    total++; if (rom_idx !== 3'd4) begin bad++; $display("FAIL run_start_romidx: got %0d want 4", rom_idx); end
  endtask

  task automatic test_reset_in_load();
    collide = 1'b1;
    step();
    collide = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    total++; if (rom_idx !== 3'd2) begin bad++; $display("FAIL mid_load_romidx: got %0d want 2", rom_idx); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (rom_idx !== 3'd0) begin bad++; $display("FAIL async_romidx: got %0d want 0", rom_idx); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL async_running: got %0d want 0", running); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (pyt(k) !== 10'd0) begin bad++; $display("FAIL async_yt%0d: got %0d want 0", k, pyt(k)); end
    end
    step();
    rst_n = 1'b1;
    tick_pulse();
    total++; if (px(0) !== 11'd640) begin bad++; $display("FAIL idle_tick_x0: got %0d want 640", px(0)); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL idle_running: got %0d want 0", running); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_load();
    test_scroll_score();
    test_respawn();
    test_back_to_back();
    test_collide();
    test_reset_in_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
